// File: rtl/avmm_axis_pkg.sv
// Shared constants for the AXI-Stream <-> Avalon-MM burst path.
// The burst writer's burstcount and the read-response stage's burst
// length are both taken from BURST_LEN so the two cannot drift apart.
package avmm_axis_pkg;

  localparam int BURST_LEN      = 28;
  localparam int BYTES_PER_BEAT = 16;
  localparam int DATA_W         = 128;
  localparam int BURSTCOUNT_W   = 7;

  // Width used for all credit arithmetic: enough headroom that
  // occupancy + outstanding + one burst never wraps.
  function automatic int credit_w(input int depth);
    return $clog2(depth) + 2;
  endfunction

endpackage

// File: rtl/rdrsp_sync_fifo.sv
// Synchronous show-ahead FIFO: the head entry is presented on rd_data
// whenever empty is low, so a write at one edge is visible right after it.
// A read and a write in the same cycle are always allowed; when full, the
// read frees the slot that the write then uses. No write-to-read bypass.
module rdrsp_sync_fifo #(
  parameter int width = 128,
  parameter int depth = 64
) (
  input  logic                     user_clk,
  input  logic                     user_resetn,
  input  logic                     wr_en,
  input  logic [width-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [width-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   occupancy
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_wr;
  logic             do_rd;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == (AW+1)'(depth));
  assign occupancy = count_reg;
  assign rd_data   = mem[rd_ptr_reg];

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Storage array: write port only, no reset on the data.
  always_ff @(posedge user_clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge user_clk) begin
    if (!user_resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    end
  end

endmodule

// File: rtl/avmm_rdrsp_axis.sv
// Avalon-MM read-return to AXI-Stream stage.
// Buffers read-return beats, re-emits them with tlast every burst_len
// beats, and grants read credit only when a whole burst fits.
// Optional macro RDRSP_UNEXPECTED_CHECK_EN: drop and flag beats that
// arrive with no outstanding read; otherwise such beats are buffered.
module avmm_rdrsp_axis
  import avmm_axis_pkg::*;
#(
  parameter int data_width       = DATA_W,
  parameter int burstcount_width = BURSTCOUNT_W,
  parameter int burst_len        = BURST_LEN,
  parameter int fifo_depth       = 64
) (
  input  logic                  user_clk,
  input  logic                  user_resetn,
  input  logic                  amm_read,
  input  logic                  amm_ready,
  input  logic [data_width-1:0] amm_readdata,
  input  logic                  amm_readdatavalid,
  output logic                  rd_credit_ok,
  output logic [data_width-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  overflow_err,
  output logic                  unexpected_err
);

  localparam int CNT_W = credit_w(fifo_depth);
  localparam int OCC_W = $clog2(fifo_depth) + 1;
  localparam int BC_W  = (burst_len > 1) ? $clog2(burst_len) : 1;
  // Each accepted read asks for exactly one writer-sized burst.
  localparam logic [burstcount_width-1:0] BURSTCOUNT = burstcount_width'(burst_len);

  logic              accept;
  logic              has_outstanding;
  logic              beat_dec;
  logic              beat_wr;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_rd;
  logic [OCC_W-1:0]  occupancy;
  logic              overflow_beat;
  logic              tlast_int;
  logic [CNT_W-1:0]  outstanding_reg;
  logic [CNT_W-1:0]  outstanding_next;
  logic [CNT_W:0]    out_sum;
  logic [CNT_W:0]    committed;
  logic [BC_W-1:0]   beat_cnt_reg;
  logic              overflow_reg;

  assign accept          = amm_read && amm_ready;
  assign has_outstanding = (outstanding_reg != '0);
  assign beat_dec        = amm_readdatavalid && has_outstanding;
  assign fifo_rd         = !fifo_empty && m_axis_tready;

`ifdef RDRSP_UNEXPECTED_CHECK_EN
  logic unexpected_reg;
  logic unexpected_beat;
  assign beat_wr         = amm_readdatavalid && has_outstanding;
  assign unexpected_beat = amm_readdatavalid && !has_outstanding;

  // Sticky flag for beats nobody asked for.
  always_ff @(posedge user_clk) begin
    if (!user_resetn) begin
      unexpected_reg <= 1'b0;
    end else if (unexpected_beat) begin
      unexpected_reg <= 1'b1;
    end
  end

  assign unexpected_err = user_resetn && unexpected_reg;
`else
  assign beat_wr        = amm_readdatavalid;
  assign unexpected_err = 1'b0;
`endif

  // A full FIFO only loses a beat if the head is not leaving this cycle.
  assign overflow_beat = beat_wr && fifo_full && !fifo_rd;

  rdrsp_sync_fifo #(
    .width (data_width),
    .depth (fifo_depth)
  ) u_fifo (
    .user_clk    (user_clk),
    .user_resetn (user_resetn),
    .wr_en       (beat_wr),
    .wr_data     (amm_readdata),
    .rd_en       (m_axis_tready),
    .rd_data     (m_axis_tdata),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .occupancy   (occupancy)
  );

  // Outstanding-beat update: add a burst on accept, retire one per
  // returned beat, saturate rather than wrap if the credit rule is ignored.
  always_comb begin
    out_sum = {1'b0, outstanding_reg};
    if (accept) begin
      out_sum = out_sum + (CNT_W+1)'(BURSTCOUNT);
    end
    if (beat_dec) begin
      out_sum = out_sum - (CNT_W+1)'(1);
    end
    outstanding_next = out_sum[CNT_W] ? '1 : out_sum[CNT_W-1:0];
  end

  // Outstanding-beat register.
  always_ff @(posedge user_clk) begin
    if (!user_resetn) begin
      outstanding_reg <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
    end
  end

  // Output beat counter marks burst boundaries on the stream.
  always_ff @(posedge user_clk) begin
    if (!user_resetn) begin
      beat_cnt_reg <= '0;
    end else if (fifo_rd) begin
      beat_cnt_reg <= tlast_int ? '0 : beat_cnt_reg + BC_W'(1);
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge user_clk) begin
    if (!user_resetn) begin
      overflow_reg <= 1'b0;
    end else if (overflow_beat) begin
      overflow_reg <= 1'b1;
    end
  end

  assign tlast_int = (beat_cnt_reg == BC_W'(burst_len - 1));

  // Credit depends only on registered state: buffered plus promised beats
  // plus one more burst must fit in the FIFO.
  assign committed    = (CNT_W+1)'(occupancy) + (CNT_W+1)'(outstanding_reg)
                      + (CNT_W+1)'(burst_len);
  assign rd_credit_ok = user_resetn && (committed <= (CNT_W+1)'(fifo_depth));

  // Outputs are forced quiet while reset is held.
  assign m_axis_tvalid = user_resetn && !fifo_empty;
  assign m_axis_tlast  = user_resetn && !fifo_empty && tlast_int;
  assign overflow_err  = user_resetn && overflow_reg;

endmodule

// File: doc/avmm_rdrsp_axis.md
# avmm_rdrsp_axis

Read-response stage that sits directly downstream of the AXI-Stream→Avalon-MM burst writer. It consumes the Avalon-MM read-return beats (amm_readdata/amm_readdatavalid) produced by that writer's read bursts, buffers them in a FIFO, and re-emits them as an AXI-Stream master with tlast on every burst boundary. It also issues a credit signal so reads are only launched when the FIFO can absorb a full burst without loss.

## Interface
- data_width, 128, width of readdata and stream data
- burstcount_width, 7, width of Avalon burstcount
- burst_len, 28, beats per read burst (must equal the writer's burstcount)
- fifo_depth, 64, FIFO entries; power of 2, >= burst_len
- user_clk  in  1  single clock for all logic
- user_resetn  in  1  reset, synchronous, active-low
- amm_read  in  1  read request from the burst writer
- amm_ready  in  1  Avalon waitrequest-inverse; read accepted when amm_read && amm_ready
- amm_readdata  in  data_width  read-return data
- amm_readdatavalid  in  1  read-return beat strobe
- rd_credit_ok  out  1  high when a new burst read may be issued
- m_axis_tdata  out  data_width  stream data
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tlast  out  1  last beat of a burst
- overflow_err  out  1  sticky: beat arrived with FIFO full
- unexpected_err  out  1  sticky: beat arrived with zero outstanding beats

## Operation
- Read accept = amm_read && amm_ready: outstanding beat counter += burst_len.
- Each amm_readdatavalid: outstanding -= 1. Simultaneous accept and beat: net += burst_len-1.
- Beat with outstanding > 0 and FIFO not full: written to FIFO.
- Beat with FIFO full: dropped; overflow_err set. This is unreachable when the credit rule is honoured.
- Beat with outstanding == 0: dropped; unexpected_err set (gated by the macro below).
- Credit: free = fifo_depth - occupancy - outstanding. rd_credit_ok = (free >= burst_len). All arithmetic is done at clog2(fifo_depth)+2 bits, unsigned, with no wrap.
- Output beat counter 0..burst_len-1 advances on each m_axis_tvalid && m_axis_tready. m_axis_tlast = (count == burst_len-1). The counter wraps to 0 on the tlast handshake.
- FIFO write and read in the same cycle are both permitted, including when the FIFO is full (read frees the slot first) or empty (write only; no bypass).
- Sticky errors clear only on reset.

## Timing
- Reset (user_resetn low at a user_clk edge) clears the FIFO, outstanding count, beat counter and errors. While user_resetn is low: m_axis_tvalid=0, m_axis_tlast=0, rd_credit_ok=0, overflow_err=0, unexpected_err=0.
- Reset mid-burst: buffered and in-flight beats are discarded. Late beats after reset count as unexpected.
- Latency: a beat with readdatavalid at edge N appears with m_axis_tvalid at N+1 (FIFO empty, registered output).
- m_axis_tdata/tlast are stable while tvalid && !tready. tvalid does not drop without a handshake.
- rd_credit_ok is a registered-state function with no combinational path from amm_read. It reflects an accept on the following cycle.
- Throughput: one beat per cycle in and out when m_axis_tready is held high.

## Configuration
- RDRSP_UNEXPECTED_CHECK_EN defined: beats with outstanding==0 are dropped and unexpected_err is set.
- RDRSP_UNEXPECTED_CHECK_EN undefined: such beats are written to the FIFO normally (outstanding saturates at 0) and unexpected_err is tied 0.

## Structure
- Shared package avmm_axis_pkg: BURST_LEN=28, BYTES_PER_BEAT=16, DATA_W=128, BURSTCOUNT_W=7. The burst writer's burstcount and this block's burst_len both use BURST_LEN.
- Sub-module rdrsp_sync_fifo: synchronous show-ahead FIFO (parameters width, depth) with full/empty/occupancy outputs. All credit, counter and error logic lives in the top.

## Test plan
- Reset then idle, tready=1 → rd_credit_ok=1, tvalid=0, both errors 0.
- One read accept, 28 consecutive beats with data 0..27 → 28 stream beats in order, tlast only on data 27, first tvalid one cycle after first readdatavalid.
- Two read accepts, m_axis_tready=0 throughout, then all 56 beats → rd_credit_ok=0 after the 2nd accept (64-56<28). Once tready=1 drains 28 beats, rd_credit_ok=1.
- Random m_axis_tready (50%) over 4 bursts → 112 beats, no loss, tlast on beats 28/56/84/112, overflow_err=0.
- readdatavalid with no prior accept → beat dropped and unexpected_err=1 with the macro defined; beat emitted and unexpected_err=0 without it.
- Reset asserted after 10 of 28 beats → outputs return to reset values. A subsequent fresh burst is emitted cleanly, with tlast on its 28th beat.
